// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Transmit end of the single-wire serial link. A WIDTH-bit word is accepted
// over a valid/ready handshake and sent as: start bit (0), data LSB first,
// stop bit (1). Each bit is held on the line for CLKS_PER_BIT clock cycles.
//
// Optional feature (compile-time macro SERIAL_FRAME_TX_PARITY_EN):
//   When defined, an even-parity bit (XOR of the data bits of the accepted
//   word) is sent between the last data bit and the stop bit.
//
// Parameters:
//   WIDTH         data bits per frame (>= 1)
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports:
//   clk        in   single clock, rising edge
//   rest       in   asynchronous active-high reset; forces idle immediately
//   tx_data    in   word to send, sampled only on accept
//   tx_valid   in   producer has a word
//   tx_ready   out  block can accept a word (high only in IDLE)
//   tx_serial  out  serial line, idles high
//   tx_busy    out  frame in progress
//   tx_done    out  one-cycle pulse on return to IDLE after the stop bit
//
// All outputs come straight from flops; tx_ready has no combinational path
// from tx_valid.
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rest,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_serial,
    output logic             tx_busy,
    output logic             tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef SERIAL_FRAME_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [IDX_W-1:0] bit_idx, idx_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [WIDTH-1:0] shreg_shifted;
    logic             bit_end;
    logic             serial_n, ready_n, busy_n, done_n;
`ifdef SERIAL_FRAME_TX_PARITY_EN
    logic             parity_q, parity_n;
`endif

    assign bit_end       = (cnt == CNT_LAST);
    assign shreg_shifted = shreg >> 1;

    // Next-state and next-output logic. The outputs are computed one cycle
    // ahead so that the registered line value lines up with the state it
    // belongs to.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = bit_idx;
        shreg_n  = shreg;
        serial_n = 1'b1;
        ready_n  = 1'b0;
        busy_n   = 1'b1;
        done_n   = 1'b0;
`ifdef SERIAL_FRAME_TX_PARITY_EN
        parity_n = parity_q;
`endif

        // The cycle counter runs in every non-idle state and wraps on each
        // bit boundary.
        if (state != S_IDLE) begin
            cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                ready_n = 1'b1;
                busy_n  = 1'b0;
                cnt_n   = '0;
                // tx_ready is high whenever the state is IDLE, so tx_valid
                // alone completes the handshake here.
                if (tx_valid) begin
                    state_n  = S_START;
                    shreg_n  = tx_data;
                    idx_n    = '0;
                    serial_n = 1'b0;
                    ready_n  = 1'b0;
                    busy_n   = 1'b1;
`ifdef SERIAL_FRAME_TX_PARITY_EN
                    parity_n = ^tx_data;
`endif
                end
            end

            S_START: begin
                serial_n = 1'b0;
                if (bit_end) begin
                    state_n  = S_DATA;
                    serial_n = shreg[0];
                end
            end

            S_DATA: begin
                serial_n = shreg[0];
                if (bit_end) begin
                    if (bit_idx == IDX_LAST) begin
`ifdef SERIAL_FRAME_TX_PARITY_EN
                        state_n  = S_PARITY;
                        serial_n = parity_q;
`else
                        state_n  = S_STOP;
                        serial_n = 1'b1;
`endif
                    end else begin
                        idx_n    = bit_idx + IDX_W'(1);
                        shreg_n  = shreg_shifted;
                        serial_n = shreg_shifted[0];
                    end
                end
            end

`ifdef SERIAL_FRAME_TX_PARITY_EN
            S_PARITY: begin
                serial_n = parity_q;
                if (bit_end) begin
                    state_n  = S_STOP;
                    serial_n = 1'b1;
                end
            end
`endif

            S_STOP: begin
                serial_n = 1'b1;
                if (bit_end) begin
                    // Return to IDLE: the done pulse coincides with the first
                    // ready cycle, so a back-to-back accept is possible here.
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end
            end

            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                ready_n = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx_serial <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= idx_n;
            shreg     <= shreg_n;
            tx_serial <= serial_n;
            tx_ready  <= ready_n;
            tx_busy   <= busy_n;
            tx_done   <= done_n;
        end
    end

`ifdef SERIAL_FRAME_TX_PARITY_EN
    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_n;
        end
    end
`endif

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Two instances share clock and reset: one with CLKS_PER_BIT=4 for directed
// and randomized single frames, one with CLKS_PER_BIT=1 for back-to-back
// streaming. Expected line values come from a frame model that lists the bits
// of a frame (start, data LSB first, optional parity, stop) and repeats each
// one CLKS_PER_BIT times.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

    localparam int W = 8;

`ifdef SERIAL_FRAME_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk;
    logic         rest;

    logic [W-1:0] d4, d1;
    logic         v4, v1;
    logic         ready4, serial4, busy4, done4;
    logic         ready1, serial1, busy1, done1;

    int           vectors;
    int           miscompares;
    bit           exp_q[$];

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(4)) dut4 (
        .clk       (clk),
        .rest      (rest),
        .tx_data   (d4),
        .tx_valid  (v4),
        .tx_ready  (ready4),
        .tx_serial (serial4),
        .tx_busy   (busy4),
        .tx_done   (done4)
    );

    serial_frame_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
        .clk       (clk),
        .rest      (rest),
        .tx_data   (d1),
        .tx_valid  (v1),
        .tx_ready  (ready1),
        .tx_serial (serial1),
        .tx_busy   (busy1),
        .tx_done   (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic idle4(input string tag);
        chk({tag, "_line4"},  serial4, 1'b1);
        chk({tag, "_ready4"}, ready4,  1'b1);
        chk({tag, "_busy4"},  busy4,   1'b0);
        chk({tag, "_done4"},  done4,   1'b0);
    endtask

    task automatic idle1(input string tag);
        chk({tag, "_line1"},  serial1, 1'b1);
        chk({tag, "_ready1"}, ready1,  1'b1);
        chk({tag, "_busy1"},  busy1,   1'b0);
        chk({tag, "_done1"},  done1,   1'b0);
    endtask

    // Reference frame: list of line values, one entry per clock cycle.
    task automatic push_frame(input logic [W-1:0] w, input int cpb);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(w[i]);
        if (PAR) bits.push_back(^w);
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k < cpb; k++) exp_q.push_back(bits[i]);
    endtask

    // Sends one word on dut4. Called at a negedge where dut4 is ready.
    // jam1/jam2: cycles at which a rejected 0x3C offer is made.
    // abort_at: cycle at which reset is pulsed mid-frame (0 = never).
    task automatic send4(input logic [W-1:0] w, input int jam1, input int jam2,
                         input int abort_at);
        int n;
        exp_q.delete();
        push_frame(w, 4);
        n = exp_q.size();
        chk("pre_accept_ready4", ready4, 1'b1);
        v4 = 1'b1;
        d4 = w;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            chk("frame_line4",  serial4, exp_q[c-1]);
            chk("frame_busy4",  busy4,   1'b1);
            chk("frame_ready4", ready4,  1'b0);
            chk("frame_done4",  done4,   1'b0);
            v4 = (c == jam1) || (c == jam2);
            d4 = v4 ? 8'h3C : W'($urandom);
            if (c == abort_at) begin
                #2 rest = 1'b1;
                #1 idle4("abort_async");
                idle1("abort_async");
                repeat (3) begin
                    @(negedge clk);
                    idle4("abort_hold");
                end
                rest = 1'b0;
                v4   = 1'b0;
                return;
            end
        end
        @(negedge clk);
        chk("end_done4",  done4,   1'b1);
        chk("end_ready4", ready4,  1'b1);
        chk("end_busy4",  busy4,   1'b0);
        chk("end_line4",  serial4, 1'b1);
        v4 = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ws[4];
        logic [W-1:0] rw;
        int           n;
        int           len4;

        vectors     = 0;
        miscompares = 0;
        rest = 1'b0;
        v4 = 1'b0; d4 = '0;
        v1 = 1'b0; d1 = '0;

        // Asynchronous reset with no clock edge in between.
        #2 rest = 1'b1;
        #1 idle4("reset_async");
        idle1("reset_async");
        repeat (3) begin
            @(negedge clk);
            idle4("reset_hold");
            idle1("reset_hold");
        end
        rest = 1'b0;
        @(negedge clk);
        idle4("post_reset");

        // Single 0xA5 frame with rejected offers of 0x3C at cycles 10 and 30.
        send4(8'hA5, 10, 30, 0);
        repeat (6) begin
            @(negedge clk);
            idle4("no_second_frame");
        end

        // Reset during DATA bit 3 (cycles 17-20), then a clean 0x5A frame.
        send4(8'hA5, 0, 0, 18);
        @(negedge clk);
        idle4("after_abort");
        send4(8'h5A, 0, 0, 0);
        @(negedge clk);
        idle4("after_5a");

        // Word with odd parity.
        send4(8'h07, 0, 0, 0);

        // Randomized words, back-to-back from the done cycle, random jams.
        len4 = (W + 2 + int'(PAR)) * 4;
        for (int r = 0; r < 6; r++) begin
            rw = W'($urandom);
            send4(rw, int'($urandom_range(2, len4)), int'($urandom_range(2, len4)), 0);
        end
        @(negedge clk);
        idle4("after_random");

        // Back-to-back streaming at one clock per bit, tx_valid held high.
        ws[0] = 8'h01;
        ws[1] = 8'hFF;
        ws[2] = W'($urandom);
        ws[3] = W'($urandom);
        v1 = 1'b1;
        d1 = ws[0];
        for (int k = 0; k < 4; k++) begin
            exp_q.delete();
            push_frame(ws[k], 1);
            n = exp_q.size();
            for (int c = 1; c <= n; c++) begin
                @(negedge clk);
                chk("b2b_line1",  serial1, exp_q[c-1]);
                chk("b2b_busy1",  busy1,   1'b1);
                chk("b2b_ready1", ready1,  1'b0);
                chk("b2b_done1",  done1,   1'b0);
                d1 = W'($urandom);
            end
            @(negedge clk);
            chk("b2b_gap_line1",  serial1, 1'b1);
            chk("b2b_gap_done1",  done1,   1'b1);
            chk("b2b_gap_ready1", ready1,  1'b1);
            chk("b2b_gap_busy1",  busy1,   1'b0);
            if (k < 3) d1 = ws[k+1];
            else       v1 = 1'b0;
        end
        repeat (3) begin
            @(negedge clk);
            idle1("b2b_end");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
